rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Parametrised rectangle fill/modify engine between the CPU core and the pixel frame memory. It accepts one rectangle command per handshake, clips it to the canvas, and walks it in raster order. It issues one pixel write per cycle in FILL mode, or read-modify-write in XOR mode. It offloads the per-pixel store loop from the core and generalises canvas size and colour depth.

## Interface
Parameters:
- IMAGE_WIDTH, 320, canvas width in pixels
- IMAGE_HEIGHT, 240, canvas height in pixels
- COLOR_BITS, 3, bits per pixel
- X_BITS, 9, coordinate width in x (must satisfy 2^X_BITS ≥ IMAGE_WIDTH)
- Y_BITS, 8, coordinate width in y (must satisfy 2^Y_BITS ≥ IMAGE_HEIGHT)

Ports:
- clk  in  1  single clock; one clock, reset synchronous active-high
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0, cmd_w  in  X_BITS each  left edge, width
- cmd_y0, cmd_h  in  Y_BITS each  top edge, height
- cmd_color  in  COLOR_BITS  fill value or XOR mask
- cmd_mode  in  1  0 = FILL, 1 = XOR
- wr_en  out  1  pixel write strobe
- wr_x / wr_y  out  X_BITS / Y_BITS  write address
- wr_data  out  COLOR_BITS  write value
- rd_x / rd_y  out  X_BITS / Y_BITS  read address (memory returns rd_data one cycle later)
- rd_data  in  COLOR_BITS  read value
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- pixel_count  out  X_BITS+Y_BITS  pixels written by the last or current command

## Operation
- States: IDLE, CLIP, FILL, XRD, XWR, DONE.
- IDLE: cmd_ready=1. When cmd_valid && cmd_ready, latch all cmd_* fields and go to CLIP.
- CLIP:
  - x_end = min(x0+w, IMAGE_WIDTH); y_end = min(y0+h, IMAGE_HEIGHT).
  - Compute the sums at X_BITS+1 / Y_BITS+1 width; they never wrap.
  - If w==0, h==0, x0≥IMAGE_WIDTH or y0≥IMAGE_HEIGHT, go to DONE with zero writes.
  - Otherwise set cur=(x0,y0), clear pixel_count, and go to FILL (mode 0) or XRD (mode 1).
- FILL: wr_en=1, address=cur, wr_data=color. Then advance the cursor.
- XRD: drive rd_x/rd_y=cur, then go to XWR.
- XWR: wr_en=1, address=cur, wr_data=rd_data^color. Then advance the cursor and return to XRD.
- Cursor advance:
  - x+1.
  - At x_end: x=x0, y+1.
  - If y+1==y_end, the next state is DONE.
- DONE: done=1 for one cycle, then IDLE.
- pixel_count increments on every wr_en and holds its value until the next CLIP.
- busy = (state != IDLE). cmd_ready = (state == IDLE).
- A cmd_valid arriving while busy is not accepted; the sender holds it.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, wr_en=0, wr_x/wr_y/wr_data=0, rd_x/rd_y=0, pixel_count=0.
- Reset mid-command aborts immediately: no further writes and no done pulse.
- Accept→first write: 2 cycles in FILL (CLIP, then FILL). In XOR the first XWR falls 3 cycles after accept.
- Throughput: FILL 1 pixel/cycle; XOR 1 pixel per 2 cycles.
- Total cycles from accept edge to done: FILL = 1 + N + 1; XOR = 1 + 2N + 1, where N is the clipped area.
- Empty or fully off-canvas command: done arrives 2 cycles after accept.
- Back-to-back: the cycle after done, cmd_ready=1. A command presented then is accepted that cycle.
- Outputs are registered from state; nothing is combinational from cmd_* to wr_*.

## Configuration
- RECT_FILL_XOR_EN defined: XOR mode (XRD/XWR, rd_* ports active) is included.
- RECT_FILL_XOR_EN undefined:
  - cmd_mode is ignored and every command executes as FILL.
  - rd_x/rd_y are tied to 0 and rd_data is unused.
  - XRD/XWR are not synthesised.

## Structure
- Shared package rect_fill_pkg holds:
  - the state enum (IDLE, CLIP, FILL, XRD, XWR, DONE);
  - the mode constants MODE_FILL=0, MODE_XOR=1;
  - a packed rect_cmd_t struct with fields x0, y0, w, h, color, mode.
- One sub-module is natural: rect_cursor. It holds the x/y counters with load, advance, and last-pixel flag.

## Test plan
- FILL (10,20,w3,h2,color 5): 6 writes at (10..12,20),(10..12,21), all data 5. done 8 cycles after accept. pixel_count=6.
- Clip (318,238,w5,h5,color 1): writes only (318..319,238..239), 4 pixels. No address ≥ canvas.
- Empty (w=0) and off-canvas (x0=400): no wr_en. done 2 cycles after accept. pixel_count=0.
- XOR (0,0,w2,h1,mask 3) with memory preloaded to 1,6: writes 2 then 5. 2 cycles per pixel. Under no RECT_FILL_XOR_EN the same stimulus writes 3,3.
- Reset asserted at the 3rd write of a 4×4 fill: no further wr_en, no done. Next cycle cmd_ready=1, busy=0.
- Back-to-back: a second command held valid during the first. It is accepted the cycle after done, and there are no lost or duplicated writes.

Source files
------------

// File: rtl/rect_fill_pkg.sv
// rect_fill shared types: FSM states, command modes, latched command.
// Coordinates are held at XY_W bits so clip sums never wrap.
package rect_fill_pkg;

  localparam int XY_W = 16;
  localparam int COLOR_W = 16;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLIP,
    FILL,
    XRD,
    XWR,
    DONE
  } state_t;

  typedef logic [XY_W-1:0] coord_t;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t w;
    coord_t h;
    logic [COLOR_W-1:0] color;
    logic mode;
  } rect_cmd_t;

  function automatic logic [XY_W:0] clip_end(
    input coord_t org,
    input coord_t len,
    input int lim
  );
    logic [XY_W:0] sum;
    logic [XY_W:0] cap;
    sum = {1'b0, org} + {1'b0, len};
    cap = (XY_W+1)'(lim);
    return (sum > cap) ? cap : sum;
  endfunction

endpackage

// File: rtl/rect_fill_if.sv
// Command handshake between the core and the rectangle fill engine.
// master = command sender, slave = engine.
interface rect_fill_if #(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8,
  parameter int COLOR_BITS = 3
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [X_BITS-1:0]     cmd_x0;
  logic [X_BITS-1:0]     cmd_w;
  logic [Y_BITS-1:0]     cmd_y0;
  logic [Y_BITS-1:0]     cmd_h;
  logic [COLOR_BITS-1:0] cmd_color;
  logic                  cmd_mode;

  modport master (
    output cmd_valid, cmd_x0, cmd_w,
    output cmd_y0, cmd_h, cmd_color, cmd_mode,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_w,
    input  cmd_y0, cmd_h, cmd_color, cmd_mode,
    output cmd_ready
  );

endinterface

// File: rtl/rect_cursor.sv
// Raster cursor over a clipped rectangle: load, advance, last-pixel flag.
// Row wrap returns x to the left edge and steps y.
module rect_cursor
  import rect_fill_pkg::*;
#(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              adv,
  input  logic [X_BITS-1:0] x0,
  input  logic [Y_BITS-1:0] y0,
  input  logic [XY_W:0]     x_end,
  input  logic [XY_W:0]     y_end,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last
);

  logic [XY_W:0] x_nx;
  logic [XY_W:0] y_nx;
  logic          row_end;

  assign x_nx = (XY_W+1)'(x) + (XY_W+1)'(1);
  assign y_nx = (XY_W+1)'(y) + (XY_W+1)'(1);
  assign row_end = (x_nx == x_end);
  assign last = row_end && (y_nx == y_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= x0;
      y <= y0;
    end else if (adv) begin
      if (row_end) begin
        x <= x0;
        y <= y + Y_BITS'(1);
      end else begin
        x <= x + X_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a command to the canvas, walks it in raster order.
// Define RECT_FILL_XOR_EN to build the read-modify-write XOR mode.
module rect_fill_engine
  import rect_fill_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int COLOR_BITS   = 3,
  parameter int X_BITS       = 9,
  parameter int Y_BITS       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  rect_fill_if.slave               cmd,
  output logic                     wr_en,
  output logic [X_BITS-1:0]        wr_x,
  output logic [Y_BITS-1:0]        wr_y,
  output logic [COLOR_BITS-1:0]    wr_data,
  output logic [X_BITS-1:0]        rd_x,
  output logic [Y_BITS-1:0]        rd_y,
  input  logic [COLOR_BITS-1:0]    rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [X_BITS+Y_BITS-1:0] pixel_count
);

  state_t state_q;
  state_t state_d;
  rect_cmd_t cmd_q;

  logic                  accept;
  logic                  empty;
  logic                  last;
  logic                  load;
  logic [XY_W:0]         x_end;
  logic [XY_W:0]         y_end;
  logic [X_BITS-1:0]     cur_x;
  logic [Y_BITS-1:0]     cur_y;
  logic [COLOR_BITS-1:0] color;
  logic                  unused_bits;

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign color = cmd_q.color[COLOR_BITS-1:0];
  assign x_end = clip_end(cmd_q.x0, cmd_q.w, IMAGE_WIDTH);
  assign y_end = clip_end(cmd_q.y0, cmd_q.h, IMAGE_HEIGHT);

  assign empty = (cmd_q.w == '0) || (cmd_q.h == '0)
    || ({1'b0, cmd_q.x0} >= (XY_W+1)'(IMAGE_WIDTH))
    || ({1'b0, cmd_q.y0} >= (XY_W+1)'(IMAGE_HEIGHT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q.x0 <= XY_W'(cmd.cmd_x0);
      cmd_q.y0 <= XY_W'(cmd.cmd_y0);
      cmd_q.w <= XY_W'(cmd.cmd_w);
      cmd_q.h <= XY_W'(cmd.cmd_h);
      cmd_q.color <= COLOR_W'(cmd.cmd_color);
`ifdef RECT_FILL_XOR_EN
      cmd_q.mode <= cmd.cmd_mode;
`else
      cmd_q.mode <= MODE_FILL;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd.cmd_valid) state_d = CLIP;
      CLIP: begin
        state_d = empty ? DONE : FILL;
`ifdef RECT_FILL_XOR_EN
        if (!empty && cmd_q.mode == MODE_XOR)
          state_d = XRD;
`endif
      end
      FILL: if (last) state_d = DONE;
`ifdef RECT_FILL_XOR_EN
      XRD: state_d = XWR;
      XWR: state_d = last ? DONE : XRD;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load = (state_q == CLIP);
  assign wr_en = (state_q == FILL) || (state_q == XWR);
  assign busy = (state_q != IDLE);
  assign cmd.cmd_ready = (state_q == IDLE);
  assign done = (state_q == DONE);
  assign wr_x = cur_x;
  assign wr_y = cur_y;

  always_comb begin
    wr_data = '0;
    unique case (1'b1)
      (state_q == FILL): wr_data = color;
`ifdef RECT_FILL_XOR_EN
      (state_q == XWR): wr_data = rd_data ^ color;
`endif
      default: wr_data = '0;
    endcase
  end

`ifdef RECT_FILL_XOR_EN
  assign rd_x = cur_x;
  assign rd_y = cur_y;
  assign unused_bits = ^{cmd_q.color, cmd_q.mode};
`else
  assign rd_x = '0;
  assign rd_y = '0;
  assign unused_bits = ^{cmd_q.color, cmd_q.mode, rd_data, cmd.cmd_mode};
`endif

  // count is per command: cleared on entry to CLIP, held after DONE
  always_ff @(posedge clk) begin
    if (reset) pixel_count <= '0;
    else if (load) pixel_count <= '0;
    else if (wr_en) pixel_count <= pixel_count + (X_BITS+Y_BITS)'(1);
  end

  rect_cursor #(
    .X_BITS(X_BITS),
    .Y_BITS(Y_BITS)
  ) u_cursor (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .adv   (wr_en),
    .x0    (cmd_q.x0[X_BITS-1:0]),
    .y0    (cmd_q.y0[Y_BITS-1:0]),
    .x_end (x_end),
    .y_end (y_end),
    .x     (cur_x),
    .y     (cur_y),
    .last  (last)
  );

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: pixel-list reference model, frame memory, random commands.
// Expectations follow RECT_FILL_XOR_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_rect_fill_engine;

  localparam int W = 320;
  localparam int H = 240;
  localparam int CB = 3;
  localparam int XB = 9;
  localparam int YB = 8;
`ifdef RECT_FILL_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en, busy, done;
  logic [XB-1:0] wr_x, rd_x;
  logic [YB-1:0] wr_y, rd_y;
  logic [CB-1:0] wr_data;
  logic [CB-1:0] rd_data = '0;
  logic [XB+YB-1:0] pixel_count;

  rect_fill_if #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB)) cmd_if ();

  rect_fill_engine #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COLOR_BITS(CB),
    .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .busy(busy), .done(done), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  // frame memory with one-cycle read latency
  logic [CB-1:0] mem [H][W] = '{default: '0};
  always @(posedge clk) begin
    if (wr_en && int'(wr_x) < W && int'(wr_y) < H)
      mem[wr_y][wr_x] <= wr_data;
    if (int'(rd_x) < W && int'(rd_y) < H) rd_data <= mem[rd_y][rd_x];
    else rd_data <= '0;
  end

  typedef struct {
    int x;
    int y;
    int c;
  } exp_t;

  exp_t q[$];
  logic [CB-1:0] ref_mem [H][W] = '{default: '0};
  int cyc = 0;
  int vecs = 0;
  int errs = 0;
  bit active = 0;
  int acc_cyc = 0, done_cyc = 0, n_px = 0, last_n = 0;
  bit m_xor = 0;
  int m_color = 0;
  int obs_wr = 0, total_wr = 0, done_cnt = 0;
  int last_done_cyc = 0, last_acc = 0, acc_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // per-cycle compare against the pixel-list model
  always @(negedge clk) begin
    bit eb;
    bit ew;
    exp_t e;
    int d, x0, y0, w, h, xe, ye;
    if (cyc >= 1) begin
      eb = active && cyc >= acc_cyc && cyc <= done_cyc;
      chk("busy", busy, eb);
      chk("cmd_ready", cmd_if.cmd_ready, !eb);
      chk("done", done, active && cyc == done_cyc);
      ew = q.size() > 0 && q[0].c == cyc;
      chk("wr_en", wr_en, ew);
      if (wr_en) begin
        obs_wr++;
        total_wr++;
      end
      if (ew) begin
        e = q.pop_front();
        d = m_xor ? (int'(ref_mem[e.y][e.x]) ^ m_color) : m_color;
        ref_mem[e.y][e.x] = CB'(d);
        if (wr_en) begin
          chk("wr_x", wr_x, e.x);
          chk("wr_y", wr_y, e.y);
          chk("wr_data", wr_data, d);
        end
      end
      if (!eb) chk("pixel_count_idle", pixel_count, last_n);
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (active && cyc == done_cyc) begin
        chk("pixel_count_done", pixel_count, n_px);
        last_n = n_px;
        active = 0;
      end
      if (reset) begin
        q.delete();
        active = 0;
        last_n = 0;
      end else if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        x0 = cmd_if.cmd_x0;
        y0 = cmd_if.cmd_y0;
        w = cmd_if.cmd_w;
        h = cmd_if.cmd_h;
        m_xor = XOR_EN && cmd_if.cmd_mode;
        m_color = cmd_if.cmd_color;
        acc_cyc = cyc + 1;
        acc_gap = acc_cyc - last_done_cyc;
        last_acc = acc_cyc;
        active = 1;
        obs_wr = 0;
        n_px = 0;
        xe = (x0 + w > W) ? W : x0 + w;
        ye = (y0 + h > H) ? H : y0 + h;
        if (w > 0 && h > 0 && x0 < W && y0 < H) begin
          for (int yy = y0; yy < ye; yy++) begin
            for (int xx = x0; xx < xe; xx++) begin
              q.push_back('{xx, yy,
                m_xor ? acc_cyc + 2 + 2 * n_px : acc_cyc + 1 + n_px});
              n_px++;
            end
          end
        end
        done_cyc = acc_cyc + (m_xor ? 2 : 1) * n_px + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x0, input int y0, input int w,
                      input int h, input int c, input int m);
    int t;
    t = 0;
    cmd_if.cmd_x0 = XB'(x0);
    cmd_if.cmd_y0 = YB'(y0);
    cmd_if.cmd_w = XB'(w);
    cmd_if.cmd_h = YB'(h);
    cmd_if.cmd_color = CB'(c);
    cmd_if.cmd_mode = (m != 0);
    cmd_if.cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_if.cmd_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) timeout("accept_timeout");
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((active || busy) && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 5000) timeout("idle_timeout");
    tick();
  endtask

  initial begin
    int dc0, tw0;
    int x0, y0, w, h;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x0 = '0;
    cmd_if.cmd_y0 = '0;
    cmd_if.cmd_w = '0;
    cmd_if.cmd_h = '0;
    cmd_if.cmd_color = '0;
    cmd_if.cmd_mode = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_x", wr_x, 0);
    chk("rst_wr_y", wr_y, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0);
    chk("rst_pixel_count", pixel_count, 0);
    tick();
    reset = 1'b0;
    tick();

    send(10, 20, 3, 2, 5, 0);
    wait_idle();
    chk("fill_writes", obs_wr, 6);
    chk("fill_done_latency", last_done_cyc - last_acc + 1, 8);
    chk("fill_pixel_count", pixel_count, 6);
    chk("fill_mem_10_20", mem[20][10], 5);
    chk("fill_mem_12_21", mem[21][12], 5);
    chk("fill_mem_13_21", mem[21][13], 0);
    chk("fill_mem_10_19", mem[19][10], 0);

    send(318, 238, 5, 5, 1, 0);
    wait_idle();
    chk("clip_writes", obs_wr, 4);
    chk("clip_mem_318_238", mem[238][318], 1);
    chk("clip_mem_319_239", mem[239][319], 1);
    chk("clip_pixel_count", pixel_count, 4);

    send(5, 5, 0, 4, 2, 0);
    wait_idle();
    chk("empty_writes", obs_wr, 0);
    chk("empty_done_latency", last_done_cyc - last_acc + 1, 2);
    chk("empty_pixel_count", pixel_count, 0);
    send(400, 5, 3, 3, 2, 0);
    wait_idle();
    chk("offx_writes", obs_wr, 0);
    chk("offx_done_latency", last_done_cyc - last_acc + 1, 2);
    send(5, 250, 3, 3, 2, 0);
    wait_idle();
    chk("offy_writes", obs_wr, 0);

    send(0, 0, 1, 1, 1, 0);
    send(1, 0, 1, 1, 6, 0);
    wait_idle();
    send(0, 0, 2, 1, 3, 1);
    wait_idle();
    chk("xor_mem_0", mem[0][0], XOR_EN ? 2 : 3);
    chk("xor_mem_1", mem[0][1], XOR_EN ? 5 : 3);
    chk("xor_done_latency", last_done_cyc - last_acc + 1,
        XOR_EN ? 6 : 4);

    dc0 = done_cnt;
    send(50, 50, 4, 4, 7, 0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mid_ready", cmd_if.cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_writes", obs_wr, 3);
    chk("rst_mid_no_done", done_cnt, dc0);
    chk("rst_mid_pixel_4", mem[50][53], 0);
    tick();

    tw0 = total_wr;
    send(100, 100, 3, 3, 2, 0);
    send(200, 150, 2, 2, 4, 0);
    chk("b2b_accept_gap", acc_gap, 2);
    wait_idle();
    chk("b2b_total_writes", total_wr - tw0, 13);

    for (int i = 0; i < 40; i++) begin
      x0 = $urandom_range(0, 319);
      if ($urandom_range(0, 3) == 0) x0 = $urandom_range(305, 335);
      y0 = $urandom_range(0, 239);
      if ($urandom_range(0, 3) == 0) y0 = $urandom_range(228, 250);
      w = $urandom_range(0, 14);
      h = $urandom_range(0, 10);
      send(x0, y0, w, h, $urandom_range(0, 7), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
